// File: rtl/mouse_hit_detector.sv
// Mouse front-end: synchronises and debounces both buttons, then turns each press
// into a single-cycle click event hit-tested against the 4x3 mole grid and the pause button.
module mouse_hit_detector #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int GRID_X0         = 80,
    parameter int GRID_Y0         = 120,
    parameter int CELL_W          = 120,
    parameter int CELL_H          = 110,
    parameter int PAUSE_X0        = 580,
    parameter int PAUSE_Y0        = 10,
    parameter int PAUSE_W         = 50,
    parameter int PAUSE_H         = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] x_pos,
    input  logic [11:0] y_pos,
    input  logic        left_btn,
    input  logic        right_btn,
    output logic [11:0] mouse_click_mole,
    output logic        mouse_click_pausebutton,
    output logic        mouse_click,
    output logic        mouse_right_click,
    output logic [3:0]  hover_cell
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // One spare bit so grid/pause limits past 4095 compare correctly.
    localparam logic [12:0] GX0 = 13'(GRID_X0);
    localparam logic [12:0] GX1 = 13'(GRID_X0 + CELL_W);
    localparam logic [12:0] GX2 = 13'(GRID_X0 + 2 * CELL_W);
    localparam logic [12:0] GX3 = 13'(GRID_X0 + 3 * CELL_W);
    localparam logic [12:0] GX4 = 13'(GRID_X0 + 4 * CELL_W);
    localparam logic [12:0] GY0 = 13'(GRID_Y0);
    localparam logic [12:0] GY1 = 13'(GRID_Y0 + CELL_H);
    localparam logic [12:0] GY2 = 13'(GRID_Y0 + 2 * CELL_H);
    localparam logic [12:0] GY3 = 13'(GRID_Y0 + 3 * CELL_H);
    localparam logic [12:0] PX0 = 13'(PAUSE_X0);
    localparam logic [12:0] PX1 = 13'(PAUSE_X0 + PAUSE_W);
    localparam logic [12:0] PY0 = 13'(PAUSE_Y0);
    localparam logic [12:0] PY1 = 13'(PAUSE_Y0 + PAUSE_H);

    function automatic logic [3:0] cell_of(input logic [11:0] x, input logic [11:0] y);
        logic [12:0] xe;
        logic [12:0] ye;
        logic [1:0]  col;
        logic [1:0]  row;
        xe  = {1'b0, x};
        ye  = {1'b0, y};
        col = 2'd0;
        if (xe >= GX1) col = 2'd1;
        if (xe >= GX2) col = 2'd2;
        if (xe >= GX3) col = 2'd3;
        row = 2'd0;
        if (ye >= GY1) row = 2'd1;
        if (ye >= GY2) row = 2'd2;
        if (xe >= GX0 && xe < GX4 && ye >= GY0 && ye < GY3)
            cell_of = {row, 2'b00} + {2'b00, col};
        else
            cell_of = 4'hF;
    endfunction

    function automatic logic pause_of(input logic [11:0] x, input logic [11:0] y);
        pause_of = ({1'b0, x} >= PX0) && ({1'b0, x} < PX1) &&
                   ({1'b0, y} >= PY0) && ({1'b0, y} < PY1);
    endfunction

    function automatic logic [11:0] onehot12(input logic [3:0] c);
        onehot12 = (c < 4'd12) ? (12'd1 << c) : 12'd0;
    endfunction

    // Index 0 = left button, index 1 = right button.
    logic [1:0]            btn_raw;
    logic [1:0]            sync1_q, sync2_q;
    logic [1:0]            db_q, db_d, db_prev_q;
    logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]            press;

    assign btn_raw = {right_btn, left_btn};

    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_LAST)
                    db_d[i] = sync2_q[i];
                else
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            cnt_q     <= cnt_d;
        end
    end

    assign press = db_q & ~db_prev_q;

    // Stage 1: capture cursor at the left press, delay the right press to match.
    logic        lvld_p1_q, rvld_p1_q;
    logic [11:0] lat_x_p1_q, lat_y_p1_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lvld_p1_q  <= 1'b0;
            rvld_p1_q  <= 1'b0;
            lat_x_p1_q <= '0;
            lat_y_p1_q <= '0;
        end else begin
            lvld_p1_q <= press[0];
            rvld_p1_q <= press[1];
            if (press[0]) begin
                lat_x_p1_q <= x_pos;
                lat_y_p1_q <= y_pos;
            end
        end
    end

    // Stage 2: hit test on the captured cursor; pause overrides any mole under it.
    logic [3:0]  hit_cell_p1;
    logic        hit_pause_p1;
    logic        click_p2_q, rclick_p2_q, pause_p2_q;
    logic [11:0] mole_p2_q;
    logic [3:0]  hover_q;

    assign hit_cell_p1  = cell_of(lat_x_p1_q, lat_y_p1_q);
    assign hit_pause_p1 = pause_of(lat_x_p1_q, lat_y_p1_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            click_p2_q  <= 1'b0;
            rclick_p2_q <= 1'b0;
            pause_p2_q  <= 1'b0;
            mole_p2_q   <= '0;
            hover_q     <= 4'hF;
        end else begin
            click_p2_q  <= lvld_p1_q;
            rclick_p2_q <= rvld_p1_q;
            pause_p2_q  <= lvld_p1_q & hit_pause_p1;
            mole_p2_q   <= (lvld_p1_q && !hit_pause_p1) ? onehot12(hit_cell_p1) : 12'd0;
            hover_q     <= cell_of(x_pos, y_pos);
        end
    end

    assign mouse_click             = click_p2_q;
    assign mouse_right_click       = rclick_p2_q;
    assign mouse_click_pausebutton = pause_p2_q;
    assign mouse_click_mole        = mole_p2_q;
    assign hover_cell              = hover_q;

endmodule

// File: tb/tb_mouse_hit_detector.sv
// Bench for mouse_hit_detector: directed cases plus randomized buttons/cursor,
// checked every cycle against a behavioural model of the click pipeline.
`timescale 1ns/1ps
module tb_mouse_hit_detector;

    localparam int D = 4;

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic [11:0] x_pos     = '0;
    logic [11:0] y_pos     = '0;
    logic        left_btn  = 1'b0;
    logic        right_btn = 1'b0;
    logic [11:0] mouse_click_mole;
    logic        mouse_click_pausebutton;
    logic        mouse_click;
    logic        mouse_right_click;
    logic [3:0]  hover_cell;

    always #5 clk = ~clk;

    mouse_hit_detector #(.DEBOUNCE_CYCLES(D)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .x_pos                   (x_pos),
        .y_pos                   (y_pos),
        .left_btn                (left_btn),
        .right_btn               (right_btn),
        .mouse_click_mole        (mouse_click_mole),
        .mouse_click_pausebutton (mouse_click_pausebutton),
        .mouse_click             (mouse_click),
        .mouse_right_click       (mouse_right_click),
        .hover_cell              (hover_cell)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference geometry computed directly with division.
    function automatic int m_cell(input int x, input int y);
        if (x < 80 || x >= 80 + 4 * 120 || y < 120 || y >= 120 + 3 * 110) return 15;
        return ((y - 120) / 110) * 4 + (x - 80) / 120;
    endfunction

    function automatic int m_pause(input int x, input int y);
        return (x >= 580 && x < 630 && y >= 10 && y < 40) ? 1 : 0;
    endfunction

    function automatic int m_mole(input int x, input int y);
        if (m_pause(x, y) != 0 || m_cell(x, y) == 15) return 0;
        return 1 << m_cell(x, y);
    endfunction

    // Behavioural model: button level seen two samples late, accepted after D
    // consecutive differing samples; a rising acceptance yields outputs two edges later
    // using the cursor sampled one edge after acceptance.
    bit h0 [2];
    bit h1 [2];
    bit db [2];
    int run [2];
    bit ev1 [2];
    bit ev2 [2];
    bit mraw [2];
    int cx, cy;
    int e_mole = 0, e_pause = 0, e_click = 0, e_rclick = 0, e_hover = 15;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                h0[i] = 0; h1[i] = 0; db[i] = 0; run[i] = 0; ev1[i] = 0; ev2[i] = 0;
            end
            cx = 0; cy = 0;
            e_mole = 0; e_pause = 0; e_click = 0; e_rclick = 0; e_hover = 15;
        end else begin
            mraw[0]  = left_btn;
            mraw[1]  = right_btn;
            e_click  = ev2[0] ? 1 : 0;
            e_mole   = ev2[0] ? m_mole(cx, cy) : 0;
            e_pause  = ev2[0] ? m_pause(cx, cy) : 0;
            e_rclick = ev2[1] ? 1 : 0;
            if (ev1[0]) begin
                cx = int'(x_pos);
                cy = int'(y_pos);
            end
            e_hover = m_cell(int'(x_pos), int'(y_pos));
            for (int i = 0; i < 2; i++) begin
                ev2[i] = ev1[i];
                ev1[i] = 0;
                if (h1[i] != db[i]) begin
                    run[i]++;
                    if (run[i] == D) begin
                        db[i]  = h1[i];
                        run[i] = 0;
                        ev1[i] = h1[i];
                    end
                end else begin
                    run[i] = 0;
                end
                h1[i] = h0[i];
                h0[i] = mraw[i];
            end
        end
    end

    always @(negedge clk) begin
        check("click",  int'(mouse_click),             e_click);
        check("rclick", int'(mouse_right_click),       e_rclick);
        check("pause",  int'(mouse_click_pausebutton), e_pause);
        check("mole",   int'(mouse_click_mole),        e_mole);
        check("hover",  int'(hover_cell),              e_hover);
    end

    // Pulse monitor for the directed expectations.
    int          n_l = 0, n_r = 0, cyc = 0, l_cyc = -1, r_cyc = -1;
    logic [11:0] last_mole  = '0;
    logic        last_pause = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (mouse_click) begin
            n_l++;
            l_cyc      = cyc;
            last_mole  = mouse_click_mole;
            last_pause = mouse_click_pausebutton;
        end
        if (mouse_right_click) begin
            n_r++;
            r_cyc = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic left_press(input int x, input int y, input string name,
                              input int exp_mole, input int exp_pause);
        int n0;
        n0        = n_l;
        x_pos     = 12'(x);
        y_pos     = 12'(y);
        left_btn  = 1'b1;
        tick(20);
        left_btn  = 1'b0;
        tick(3 * D + 6);
        check({name, "_count"}, n_l - n0, 1);
        check({name, "_mole"},  int'(last_mole), exp_mole);
        check({name, "_pause"}, int'(last_pause), exp_pause);
    endtask

    int xs [16] = '{0, 79, 80, 199, 200, 319, 320, 439, 440, 559, 560, 579, 580, 629, 630, 4095};
    int ys [14] = '{0, 9, 10, 39, 40, 119, 120, 229, 230, 339, 340, 449, 450, 4095};

    initial begin
        int n0, nr0;

        tick(3);
        check("rst_hover", int'(hover_cell), 15);
        check("rst_click", int'(mouse_click), 0);
        check("rst_mole",  int'(mouse_click_mole), 0);
        reset = 1'b1;
        tick(3);

        check("pin_cell_80_120",  m_cell(80, 120), 0);
        check("pin_mole_559_449", m_mole(559, 449), 12'h800);
        check("pin_mole_560_449", m_mole(560, 449), 0);
        check("pin_mole_200_230", m_mole(200, 230), 12'h020);
        check("pin_pause_600_20", m_pause(600, 20), 1);

        left_press(80, 120,  "corner",  12'h001, 0);
        left_press(559, 449, "last",    12'h800, 0);
        left_press(560, 449, "miss",    12'h000, 0);
        left_press(200, 230, "r1c1",    12'h020, 0);
        left_press(600, 20,  "pausebt", 12'h000, 1);

        n0 = n_l;
        repeat (5) begin
            left_btn = 1'b1; tick(3);
            left_btn = 1'b0; tick(3);
        end
        tick(10);
        check("glitch3_none", n_l - n0, 0);
        left_btn = 1'b1; tick(4);
        left_btn = 1'b0; tick(20);
        check("glitch4_one", n_l - n0, 1);

        n0 = n_l; nr0 = n_r;
        x_pos = 12'd0; y_pos = 12'd0;
        left_btn = 1'b1; right_btn = 1'b1; tick(15);
        left_btn = 1'b0; right_btn = 1'b0; tick(15);
        check("both_left",  n_l - n0, 1);
        check("both_right", n_r - nr0, 1);
        check("both_same_cycle", l_cyc, r_cyc);
        check("both_mole",  int'(last_mole), 0);
        check("both_pause", int'(last_pause), 0);

        n0 = n_l;
        x_pos = 12'd300; y_pos = 12'd300;
        left_btn = 1'b1; tick(2);
        reset = 1'b0; #1;
        check("midrst_hover", int'(hover_cell), 15);
        check("midrst_click", int'(mouse_click), 0);
        tick(3);
        check("midrst_mole", int'(mouse_click_mole), 0);
        reset = 1'b1;
        tick(20);
        check("postrst_count", n_l - n0, 1);
        check("postrst_mole",  int'(last_mole), 12'h020);
        left_btn = 1'b0; tick(15);

        y_pos = 12'd230;
        x_pos = 12'd199; tick(1);
        check("hover_199", int'(hover_cell), 4);
        x_pos = 12'd200; tick(1);
        check("hover_200", int'(hover_cell), 5);

        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(5) == 0) left_btn = ~left_btn;
            if ($urandom_range(7) == 0) right_btn = ~right_btn;
            if ($urandom_range(2) == 0)
                x_pos = ($urandom_range(1) == 0) ? 12'(xs[$urandom_range(15)]) : 12'($urandom_range(700));
            if ($urandom_range(2) == 0)
                y_pos = ($urandom_range(1) == 0) ? 12'(ys[$urandom_range(13)]) : 12'($urandom_range(500));
            if ($urandom_range(799) == 0) begin
                reset = 1'b0;
                tick(2);
                reset = 1'b1;
            end
            tick(1);
        end
        left_btn = 1'b0; right_btn = 1'b0;
        tick(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mouse_hit_detector.md
Name: mouse_hit_detector

Overview:
- Upstream stage of the game core: turns raw mouse state (x_pos, y_pos, left_btn, right_btn) into single-cycle click events.
- Events produced: per-mole hit vector, pause-button hit, generic left click, right click. The game FSM consumes them directly.
- Internals: synchronises and debounces both buttons, latches the cursor at press time, hit-tests against the 4x3 mole grid and the pause button.
- Also exports a registered hover cell for the display path.

Parameters:
- DEBOUNCE_CYCLES, 100000: consecutive stable cycles before a button level change is accepted; must be >= 1.
- GRID_X0, 80: left edge of mole grid (pixels).
- GRID_Y0, 120: top edge of mole grid.
- CELL_W, 120: cell width; 4 columns.
- CELL_H, 110: cell height; 3 rows.
- PAUSE_X0, 580: pause button left edge.
- PAUSE_Y0, 10: pause button top edge.
- PAUSE_W, 50: pause button width.
- PAUSE_H, 30: pause button height.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- x_pos  in  12  cursor X, pixels
- y_pos  in  12  cursor Y, pixels
- left_btn  in  1  raw left button, asynchronous
- right_btn  in  1  raw right button, asynchronous
- mouse_click_mole  out  12  one-hot hit pulse; bit = row*4+col
- mouse_click_pausebutton  out  1  pause button hit pulse
- mouse_click  out  1  any left press pulse
- mouse_right_click  out  1  right press pulse
- hover_cell  out  4  cell under cursor, 0-11; 4'hF when outside grid

Behaviour:
- Reset (reset=0, async): all outputs 0 except hover_cell=4'hF. Synchronisers, debounced states, counters and latches all cleared.
- Synchroniser: 2-flop chain per button. Raw inputs are used nowhere else.
- Debounce, per button, independent:
  - counter width $clog2(DEBOUNCE_CYCLES+1).
  - When synced level != debounced state, counter increments; otherwise counter clears.
  - When counter reaches DEBOUNCE_CYCLES-1 while still differing, debounced state flips and counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES is never accepted.
- Press event: rising edge of debounced state, one cycle. Falling edge produces nothing. A held button yields exactly one event.
- Stage 1, on a left press event in cycle T: latch x_pos/y_pos sampled in cycle T. Right press event is delayed one register.
- Stage 2, cycle T+1, combinational hit test on latched coordinates:
  - Edges inclusive on left/top, exclusive on right/bottom.
  - Column found by compare chain against GRID_X0 + k*CELL_W, k=1..3; row likewise. No dividers.
  - Pause hit when PAUSE_X0 <= x < PAUSE_X0+PAUSE_W and PAUSE_Y0 <= y < PAUSE_Y0+PAUSE_H.
  - If pause and grid regions overlap, pause wins and the mole vector is 0.
- Outputs registered at end of T+1 and high for exactly cycle T+2, so latency is 2 cycles from the debounced edge:
  - mouse_click = 1.
  - mouse_click_mole: one-hot, or 0 if outside grid.
  - mouse_click_pausebutton as tested.
- Right click pulse also appears in cycle T+2 relative to its own debounced edge.
- Simultaneous left and right press events: both pulses in the same cycle, independent.
- Back-to-back events: impossible faster than 2*DEBOUNCE_CYCLES apart. The pipeline does not need to hold more than one event.
- hover_cell: registered every cycle from live x_pos/y_pos, using the same edge rules, 1-cycle latency. Pause overlap has no effect on it.
- Reset mid-operation:
  - In-flight pulses are dropped.
  - A button held through reset release is seen as a new press after DEBOUNCE_CYCLES+2 sync cycles, because the debounced state restarts at 0.
- Coordinates >= 4096 cannot occur (12-bit). Values past grid or pause limits are simply misses.

Test Plan:
- Bench parameter: DEBOUNCE_CYCLES=4.
- Hold left_btn with x=80, y=120 -> one cycle of mouse_click=1 and mouse_click_mole=12'h001; no further pulses while held or on release.
- Press at x=559, y=449 -> mole bit 11 (12'h800). Press at x=560, y=449 -> mouse_click=1, mouse_click_mole=0.
- Press at x=200, y=230 -> bit 5 (row 1, col 1). Separately, press at x=600, y=20 -> mouse_click_pausebutton=1, mole=0.
- left_btn glitch high for 3 cycles, repeated -> no output pulse. High for 4+ sync cycles -> exactly one pulse.
- left and right pressed on the same cycle at x=0, y=0 -> mouse_click=1 and mouse_right_click=1 in the same cycle, mole=0, pause=0.
- Assert reset=0 mid-debounce with left held, then release reset -> outputs 0 and hover_cell=4'hF during reset; one mouse_click pulse after reset release. Sweep x across 199/200 at y=230 -> hover_cell goes 4 then 5 one cycle later.
